// File: rtl/nwr_pattern_gen.sv
// NWRITE traffic generator: emits runs of programmable-length packets on the user
// request stream, one packet per NWRITE engine ready/done handshake.
module nwr_pattern_gen #(
   parameter int DATA_W    = 64,
   parameter int ADDR_W    = 34,
   parameter int LEN_W     = 9,
   parameter int MAX_BYTES = 256,
   parameter int CNT_W     = 16,
   parameter int BYTES     = DATA_W / 8
) (
   input  logic              log_clk,
   input  logic              log_rst,
   input  logic              start_in,
   input  logic              stop_in,
   input  logic [LEN_W-1:0]  cfg_len_in,
   input  logic [ADDR_W-1:0] cfg_base_addr_in,
   input  logic [ADDR_W-1:0] cfg_addr_step_in,
   input  logic [CNT_W-1:0]  cfg_pkt_count_in,
   input  logic [1:0]        cfg_mode_in,
   input  logic [DATA_W-1:0] cfg_fill_in,
   input  logic              nwr_ready_in,
   input  logic              nwr_busy_in,
   input  logic              nwr_done_in,
   input  logic              user_tready_in,
   output logic [ADDR_W-1:0] user_addr_o,
   output logic [19:0]       user_tsize_o,
   output logic [DATA_W-1:0] user_tdata_o,
   output logic              user_tvalid_o,
   output logic              user_tfirst_o,
   output logic              user_tlast_o,
   output logic [BYTES-1:0]  user_tkeep_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              cfg_err_o,
   output logic [CNT_W-1:0]  pkt_cnt_o
);

   localparam int BSH   = $clog2(BYTES);
   localparam int IDX_W = $clog2(DATA_W);

   typedef enum logic [1:0] {IDLE, WAIT_RDY, SEND, WAIT_DONE} state_t;

   state_t             state_reg, state_next;
   logic [LEN_W-1:0]   len_reg;
   logic [ADDR_W-1:0]  step_reg;
   logic [CNT_W-1:0]   count_reg;
   logic [1:0]         mode_reg;
   logic [DATA_W-1:0]  fill_reg;
   logic [ADDR_W-1:0]  addr_reg;
   logic [19:0]        tsize_reg;
   logic [DATA_W-1:0]  tdata_reg;
   logic               tvalid_reg;
   logic [LEN_W-1:0]   beat_idx_reg;
   logic [DATA_W-1:0]  g_reg;
   logic [CNT_W-1:0]   pkt_cnt_reg;
   logic               stop_pend_reg;
   logic               busy_reg;
   logic               done_reg;
   logic               err_reg;

   logic               load_cfg, cfg_err, launch, accept, pkt_done, next_pkt, run_end;
   logic               len_legal, stop_any, is_last;
   logic [LEN_W-1:0]   last_idx;
   logic [BYTES-1:0]   last_keep;
   logic [BSH-1:0]     rem;

   function automatic logic [DATA_W-1:0] pattern(input logic [1:0] mode,
                                                 input logic [DATA_W-1:0] g,
                                                 input logic [DATA_W-1:0] fill);
      case (mode)
         2'd0:    pattern = g;
         2'd1:    pattern = {{(DATA_W-1){1'b0}}, 1'b1} << g[IDX_W-1:0];
         2'd2:    pattern = fill;
         default: pattern = ~g;
      endcase
   endfunction

   // last beat index = ceil(len/BYTES)-1 = (len-1)/BYTES, len is never 0 once latched
   assign last_idx  = LEN_W'(len_reg - LEN_W'(1)) >> BSH;
   assign rem       = len_reg[BSH-1:0];
   assign last_keep = (rem == '0) ? '1 : ~({BYTES{1'b1}} >> rem);
   assign is_last   = (beat_idx_reg == last_idx);
   assign len_legal = (cfg_len_in != '0) && (cfg_len_in <= LEN_W'(MAX_BYTES));
   assign stop_any  = stop_pend_reg | stop_in;
   assign accept    = (state_reg == SEND) && tvalid_reg && user_tready_in;

   always_ff @(posedge log_clk) begin
      if (log_rst) state_reg <= IDLE;
      else         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      load_cfg   = 1'b0;
      cfg_err    = 1'b0;
      launch     = 1'b0;
      pkt_done   = 1'b0;
      next_pkt   = 1'b0;
      run_end    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start_in) begin
               if (len_legal) begin
                  load_cfg   = 1'b1;
                  state_next = WAIT_RDY;
               end else begin
                  cfg_err = 1'b1;
               end
            end
         end
         WAIT_RDY: begin
            if (stop_any) begin
               run_end    = 1'b1;
               state_next = IDLE;
            end else if (nwr_ready_in && !nwr_busy_in) begin
               launch     = 1'b1;
               state_next = SEND;
            end
         end
         SEND: begin
            if (accept && is_last) state_next = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (nwr_done_in) begin
               pkt_done = 1'b1;
               if (((count_reg != '0) && (CNT_W'(pkt_cnt_reg + CNT_W'(1)) == count_reg)) || stop_any) begin
                  run_end    = 1'b1;
                  state_next = IDLE;
               end else begin
                  next_pkt   = 1'b1;
                  state_next = WAIT_RDY;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge log_clk) begin
      if (log_rst) begin
         len_reg       <= '0;
         step_reg      <= '0;
         count_reg     <= '0;
         mode_reg      <= '0;
         fill_reg      <= '0;
         addr_reg      <= '0;
         tsize_reg     <= '0;
         tdata_reg     <= '0;
         tvalid_reg    <= 1'b0;
         beat_idx_reg  <= '0;
         g_reg         <= '0;
         pkt_cnt_reg   <= '0;
         stop_pend_reg <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         done_reg <= run_end;
         err_reg  <= cfg_err;
         if (load_cfg) begin
            len_reg       <= cfg_len_in;
            step_reg      <= cfg_addr_step_in;
            count_reg     <= cfg_pkt_count_in;
            mode_reg      <= cfg_mode_in;
            fill_reg      <= cfg_fill_in;
            addr_reg      <= cfg_base_addr_in;
            tsize_reg     <= 20'(cfg_len_in - LEN_W'(1));
            pkt_cnt_reg   <= '0;
            g_reg         <= '0;
            beat_idx_reg  <= '0;
            stop_pend_reg <= 1'b0;
            busy_reg      <= 1'b1;
         end
         if (stop_in && (state_reg != IDLE)) stop_pend_reg <= 1'b1;
         if (launch) begin
            tvalid_reg   <= 1'b1;
            beat_idx_reg <= '0;
            tdata_reg    <= pattern(mode_reg, g_reg, fill_reg);
         end
         // g_reg tracks the beat on the bus, so the next beat's data uses g_reg+1
         if (accept) begin
            g_reg <= g_reg + DATA_W'(1);
            if (is_last) begin
               tvalid_reg <= 1'b0;
            end else begin
               beat_idx_reg <= beat_idx_reg + LEN_W'(1);
               tdata_reg    <= pattern(mode_reg, g_reg + DATA_W'(1), fill_reg);
            end
         end
         if (pkt_done) pkt_cnt_reg <= pkt_cnt_reg + CNT_W'(1);
         if (next_pkt) addr_reg <= addr_reg + step_reg;
         if (run_end) begin
            busy_reg      <= 1'b0;
            stop_pend_reg <= 1'b0;
         end
      end
   end

   assign user_addr_o   = addr_reg;
   assign user_tsize_o  = tsize_reg;
   assign user_tdata_o  = tdata_reg;
   assign user_tvalid_o = tvalid_reg;
   assign user_tfirst_o = tvalid_reg && (beat_idx_reg == '0);
   assign user_tlast_o  = tvalid_reg && is_last;
   assign user_tkeep_o  = !tvalid_reg ? '0 : (is_last ? last_keep : '1);
   assign busy_o        = busy_reg;
   assign done_o        = done_reg;
   assign cfg_err_o     = err_reg;
   assign pkt_cnt_o     = pkt_cnt_reg;

endmodule

// File: tb/tb_nwr_pattern_gen.sv
// Directed bench for nwr_pattern_gen: drives and samples on the falling edge,
// expected values are hand-derived constants per scenario.
module tb_nwr_pattern_gen;

   logic        log_clk;
   logic        log_rst;
   logic        start_in, stop_in;
   logic [8:0]  cfg_len_in;
   logic [33:0] cfg_base_addr_in, cfg_addr_step_in;
   logic [15:0] cfg_pkt_count_in;
   logic [1:0]  cfg_mode_in;
   logic [63:0] cfg_fill_in;
   logic        nwr_ready_in, nwr_busy_in, nwr_done_in, user_tready_in;
   logic [33:0] user_addr_o;
   logic [19:0] user_tsize_o;
   logic [63:0] user_tdata_o;
   logic        user_tvalid_o, user_tfirst_o, user_tlast_o;
   logic [7:0]  user_tkeep_o;
   logic        busy_o, done_o, cfg_err_o;
   logic [15:0] pkt_cnt_o;

   int checks = 0;
   int errors = 0;

   logic [63:0] d_q [64];
   logic [7:0]  k_q [64];
   logic        f_q [64];
   logic        l_q [64];
   logic [33:0] a_q [64];

   nwr_pattern_gen dut (
      .log_clk(log_clk), .log_rst(log_rst), .start_in(start_in), .stop_in(stop_in),
      .cfg_len_in(cfg_len_in), .cfg_base_addr_in(cfg_base_addr_in),
      .cfg_addr_step_in(cfg_addr_step_in), .cfg_pkt_count_in(cfg_pkt_count_in),
      .cfg_mode_in(cfg_mode_in), .cfg_fill_in(cfg_fill_in),
      .nwr_ready_in(nwr_ready_in), .nwr_busy_in(nwr_busy_in), .nwr_done_in(nwr_done_in),
      .user_tready_in(user_tready_in), .user_addr_o(user_addr_o), .user_tsize_o(user_tsize_o),
      .user_tdata_o(user_tdata_o), .user_tvalid_o(user_tvalid_o), .user_tfirst_o(user_tfirst_o),
      .user_tlast_o(user_tlast_o), .user_tkeep_o(user_tkeep_o), .busy_o(busy_o),
      .done_o(done_o), .cfg_err_o(cfg_err_o), .pkt_cnt_o(pkt_cnt_o)
   );

   initial log_clk = 1'b0;
   always #5 log_clk = ~log_clk;

   task automatic tick();
      @(negedge log_clk);
   endtask

   task automatic pulse_start(input int len, input logic [33:0] base, input logic [33:0] step,
                              input int count, input int mode, input logic [63:0] fill);
      cfg_len_in       = 9'(len);
      cfg_base_addr_in = base;
      cfg_addr_step_in = step;
      cfg_pkt_count_in = 16'(count);
      cfg_mode_in      = 2'(mode);
      cfg_fill_in      = fill;
      start_in         = 1'b1;
      tick();
      start_in         = 1'b0;
   endtask

   task automatic engine_done();
      nwr_done_in = 1'b1;
      tick();
      nwr_done_in = 1'b0;
   endtask

   // Collects one packet with tready held high; returns beat count and timeout flag.
   task automatic get_packet(output int n, output bit to);
      bit fin = 1'b0;
      n  = 0;
      to = 1'b1;
      user_tready_in = 1'b1;
      for (int c = 0; c < 200 && !fin; c++) begin
         if (user_tvalid_o) begin
            d_q[n] = user_tdata_o;
            k_q[n] = user_tkeep_o;
            f_q[n] = user_tfirst_o;
            l_q[n] = user_tlast_o;
            a_q[n] = user_addr_o;
            n++;
            if (user_tlast_o || n >= 64) begin
               fin = 1'b1;
               to  = !user_tlast_o;
            end
         end
         tick();
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({user_tvalid_o, user_tfirst_o, user_tlast_o, busy_o, done_o, cfg_err_o} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags got %b want 000000",
                  {user_tvalid_o, user_tfirst_o, user_tlast_o, busy_o, done_o, cfg_err_o});
      end
      checks++;
      if ({user_tkeep_o, user_addr_o, user_tsize_o, user_tdata_o, pkt_cnt_o} !== '0) begin
         errors++;
         $display("FAIL reset_buses keep=%h addr=%h tsize=%h data=%h cnt=%0d want all 0",
                  user_tkeep_o, user_addr_o, user_tsize_o, user_tdata_o, pkt_cnt_o);
      end
      $display("test_reset done");
   endtask

   task automatic test_basic();
      int n; bit to;
      logic [7:0] ek [3];
      ek[0] = 8'hFF; ek[1] = 8'hFF; ek[2] = 8'hF0;
      pulse_start(20, 34'h100, 34'h0, 1, 0, 64'h0);
      checks++;
      if (busy_o !== 1'b1 || user_tvalid_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_start busy=%b tvalid=%b want busy=1 tvalid=0", busy_o, user_tvalid_o);
      end
      checks++;
      if (user_tsize_o !== 20'd19 || user_addr_o !== 34'h100) begin
         errors++;
         $display("FAIL basic_hdr tsize=%0d addr=%h want 19 100", user_tsize_o, user_addr_o);
      end
      tick();
      checks++;
      if (user_tvalid_o !== 1'b1 || user_tfirst_o !== 1'b1) begin
         errors++;
         $display("FAIL basic_latency tvalid=%b tfirst=%b want 1 1", user_tvalid_o, user_tfirst_o);
      end
      get_packet(n, to);
      checks++;
      if (to || n != 3) begin
         errors++;
         $display("FAIL basic_beats got %0d timeout=%0d want 3", n, to);
      end
      for (int i = 0; i < 3 && i < n; i++) begin
         checks++;
         if (d_q[i] !== 64'(i) || k_q[i] !== ek[i] || f_q[i] !== (i == 0) || l_q[i] !== (i == 2)) begin
            errors++;
            $display("FAIL basic_beat%0d data=%h keep=%h f=%b l=%b want %h %h %b %b",
                     i, d_q[i], k_q[i], f_q[i], l_q[i], 64'(i), ek[i], i == 0, i == 2);
         end
      end
      checks++;
      if (user_tvalid_o !== 1'b0 || busy_o !== 1'b1 || done_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_post_last tvalid=%b busy=%b done=%b want 0 1 0", user_tvalid_o, busy_o, done_o);
      end
      engine_done();
      checks++;
      if (done_o !== 1'b1 || busy_o !== 1'b0 || pkt_cnt_o !== 16'd1) begin
         errors++;
         $display("FAIL basic_done done=%b busy=%b cnt=%0d want 1 0 1", done_o, busy_o, pkt_cnt_o);
      end
      tick();
      checks++;
      if (done_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_pulse done=%b want 0", done_o);
      end
      $display("test_basic done");
   endtask

   task automatic test_multi_packet();
      int n; bit to;
      pulse_start(256, 34'h0, 34'h100, 3, 3, 64'h0);
      checks++;
      if (user_tsize_o !== 20'd255) begin
         errors++;
         $display("FAIL multi_tsize got %0d want 255", user_tsize_o);
      end
      for (int p = 0; p < 3; p++) begin
         get_packet(n, to);
         checks++;
         if (to || n != 32 || a_q[0] !== 34'(p * 256) || a_q[31] !== 34'(p * 256)) begin
            errors++;
            $display("FAIL multi_pkt%0d beats=%0d addr=%h/%h want 32 %h", p, n, a_q[0], a_q[31], 34'(p * 256));
         end
         checks++;
         if (d_q[0] !== ~64'(p * 32) || k_q[31] !== 8'hFF || l_q[31] !== 1'b1) begin
            errors++;
            $display("FAIL multi_data%0d beat0=%h lastkeep=%h want %h FF", p, d_q[0], k_q[31], ~64'(p * 32));
         end
         engine_done();
         checks++;
         if (pkt_cnt_o !== 16'(p + 1) || done_o !== (p == 2)) begin
            errors++;
            $display("FAIL multi_cnt%0d cnt=%0d done=%b want %0d %b", p, pkt_cnt_o, done_o, p + 1, p == 2);
         end
      end
      $display("test_multi_packet done");
   endtask

   task automatic test_stall();
      logic [63:0] sd; logic [7:0] sk; logic sf, sl; bit seen;
      pulse_start(8, 34'h20, 34'h8, 2, 0, 64'h0);
      for (int p = 0; p < 2; p++) begin
         user_tready_in = 1'b0;
         seen = 1'b0;
         for (int c = 0; c < 20 && !seen; c++) begin
            if (user_tvalid_o) seen = 1'b1;
            else tick();
         end
         checks++;
         if (!seen) begin
            errors++;
            $display("FAIL stall_wait%0d tvalid never rose", p);
         end
         sd = user_tdata_o; sk = user_tkeep_o; sf = user_tfirst_o; sl = user_tlast_o;
         tick();
         checks++;
         if (user_tvalid_o !== 1'b1 || user_tdata_o !== sd || user_tkeep_o !== sk ||
             user_tfirst_o !== sf || user_tlast_o !== sl) begin
            errors++;
            $display("FAIL stall_hold%0d v=%b data=%h keep=%h want 1 %h %h", p, user_tvalid_o, user_tdata_o, user_tkeep_o, sd, sk);
         end
         user_tready_in = 1'b1;
         checks++;
         if (user_tdata_o !== 64'(p) || user_tkeep_o !== 8'hFF || user_tfirst_o !== 1'b1 || user_tlast_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_beat%0d data=%h keep=%h f=%b l=%b want %h FF 1 1",
                     p, user_tdata_o, user_tkeep_o, user_tfirst_o, user_tlast_o, 64'(p));
         end
         tick();
         checks++;
         if (user_tvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_after%0d tvalid=%b want 0", p, user_tvalid_o);
         end
         engine_done();
      end
      checks++;
      if (done_o !== 1'b1 || pkt_cnt_o !== 16'd2) begin
         errors++;
         $display("FAIL stall_done done=%b cnt=%0d want 1 2", done_o, pkt_cnt_o);
      end
      $display("test_stall done");
   endtask

   task automatic test_continuous_stop();
      int n; bit to; bit seen;
      pulse_start(16, 34'h1000, 34'h10, 0, 1, 64'h0);
      for (int p = 0; p < 3; p++) begin
         get_packet(n, to);
         checks++;
         if (to || n != 2 || d_q[0] !== (64'd1 << (2 * p)) || d_q[1] !== (64'd1 << (2 * p + 1))) begin
            errors++;
            $display("FAIL cont_pkt%0d beats=%0d d0=%h d1=%h want 2 %h %h",
                     p, n, d_q[0], d_q[1], 64'd1 << (2 * p), 64'd1 << (2 * p + 1));
         end
         engine_done();
         checks++;
         if (busy_o !== 1'b1 || pkt_cnt_o !== 16'(p + 1) || user_addr_o !== 34'h1000 + 34'(16 * (p + 1))) begin
            errors++;
            $display("FAIL cont_cnt%0d busy=%b cnt=%0d addr=%h want 1 %0d %h",
                     p, busy_o, pkt_cnt_o, user_addr_o, p + 1, 34'h1000 + 34'(16 * (p + 1)));
         end
      end
      user_tready_in = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         if (user_tvalid_o) seen = 1'b1;
         else tick();
      end
      checks++;
      if (!seen || user_tdata_o !== (64'd1 << 6) || user_tfirst_o !== 1'b1) begin
         errors++;
         $display("FAIL cont_p4b0 seen=%b data=%h first=%b want 1 %h 1", seen, user_tdata_o, user_tfirst_o, 64'd1 << 6);
      end
      tick();
      checks++;
      if (user_tdata_o !== (64'd1 << 7) || user_tlast_o !== 1'b1) begin
         errors++;
         $display("FAIL cont_p4b1 data=%h last=%b want %h 1", user_tdata_o, user_tlast_o, 64'd1 << 7);
      end
      stop_in = 1'b1;
      tick();
      stop_in = 1'b0;
      checks++;
      if (user_tvalid_o !== 1'b0 || busy_o !== 1'b1 || done_o !== 1'b0) begin
         errors++;
         $display("FAIL cont_stop_wait tvalid=%b busy=%b done=%b want 0 1 0", user_tvalid_o, busy_o, done_o);
      end
      engine_done();
      checks++;
      if (done_o !== 1'b1 || busy_o !== 1'b0 || pkt_cnt_o !== 16'd4) begin
         errors++;
         $display("FAIL cont_stop_done done=%b busy=%b cnt=%0d want 1 0 4", done_o, busy_o, pkt_cnt_o);
      end
      tick();
      $display("test_continuous_stop done");
   endtask

   task automatic test_cfg_err();
      int bad [2];
      bad[0] = 0; bad[1] = 257;
      for (int i = 0; i < 2; i++) begin
         pulse_start(bad[i], 34'h0, 34'h0, 1, 0, 64'h0);
         checks++;
         if (cfg_err_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_len%0d err=%b busy=%b want 1 0", bad[i], cfg_err_o, busy_o);
         end
         tick();
         checks++;
         if (cfg_err_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_pulse%0d err=%b busy=%b want 0 0", bad[i], cfg_err_o, busy_o);
         end
      end
      nwr_ready_in = 1'b0;
      pulse_start(8, 34'h40, 34'h0, 1, 0, 64'h0);
      pulse_start(16, 34'h80, 34'h0, 1, 0, 64'h0);
      checks++;
      if (busy_o !== 1'b1 || user_addr_o !== 34'h40 || user_tsize_o !== 20'd7 || cfg_err_o !== 1'b0) begin
         errors++;
         $display("FAIL start_while_busy busy=%b addr=%h tsize=%0d err=%b want 1 40 7 0",
                  busy_o, user_addr_o, user_tsize_o, cfg_err_o);
      end
      nwr_ready_in = 1'b1;
      nwr_busy_in  = 1'b1;
      tick();
      tick();
      checks++;
      if (user_tvalid_o !== 1'b0) begin
         errors++;
         $display("FAIL engine_busy_gate tvalid=%b want 0", user_tvalid_o);
      end
      stop_in = 1'b1;
      tick();
      stop_in = 1'b0;
      nwr_busy_in = 1'b0;
      checks++;
      if (done_o !== 1'b1 || busy_o !== 1'b0 || pkt_cnt_o !== 16'd0) begin
         errors++;
         $display("FAIL stop_in_wait_rdy done=%b busy=%b cnt=%0d want 1 0 0", done_o, busy_o, pkt_cnt_o);
      end
      tick();
      $display("test_cfg_err done");
   endtask

   task automatic test_mid_reset();
      int n; bit to; bit seen;
      user_tready_in = 1'b0;
      pulse_start(24, 34'h55, 34'h0, 1, 0, 64'h0);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         if (user_tvalid_o) seen = 1'b1;
         else tick();
      end
      log_rst = 1'b1;
      tick();
      checks++;
      if (!seen || {user_tvalid_o, user_tfirst_o, user_tlast_o, busy_o, done_o} !== 5'b0 ||
          user_tkeep_o !== 8'h0 || user_addr_o !== 34'h0 || user_tsize_o !== 20'h0 || user_tdata_o !== 64'h0) begin
         errors++;
         $display("FAIL mid_reset seen=%b v=%b busy=%b keep=%h addr=%h tsize=%h want all 0",
                  seen, user_tvalid_o, busy_o, user_tkeep_o, user_addr_o, user_tsize_o);
      end
      log_rst = 1'b0;
      pulse_start(1, 34'h7, 34'h0, 1, 2, 64'hA5A5_5A5A_0123_4567);
      get_packet(n, to);
      checks++;
      if (to || n != 1 || k_q[0] !== 8'h80 || f_q[0] !== 1'b1 || l_q[0] !== 1'b1) begin
         errors++;
         $display("FAIL len1_beat beats=%0d keep=%h f=%b l=%b want 1 80 1 1", n, k_q[0], f_q[0], l_q[0]);
      end
      checks++;
      if (d_q[0] !== 64'hA5A5_5A5A_0123_4567 || a_q[0] !== 34'h7) begin
         errors++;
         $display("FAIL len1_data data=%h addr=%h want a5a55a5a01234567 7", d_q[0], a_q[0]);
      end
      engine_done();
      checks++;
      if (done_o !== 1'b1 || pkt_cnt_o !== 16'd1) begin
         errors++;
         $display("FAIL len1_done done=%b cnt=%0d want 1 1", done_o, pkt_cnt_o);
      end
      $display("test_mid_reset done");
   endtask

   initial begin
      log_rst = 1'b1;
      start_in = 1'b0; stop_in = 1'b0;
      cfg_len_in = '0; cfg_base_addr_in = '0; cfg_addr_step_in = '0;
      cfg_pkt_count_in = '0; cfg_mode_in = '0; cfg_fill_in = '0;
      nwr_ready_in = 1'b1; nwr_busy_in = 1'b0; nwr_done_in = 1'b0;
      user_tready_in = 1'b1;
      tick();
      tick();
      test_reset();
      log_rst = 1'b0;
      tick();
      test_basic();
      test_multi_packet();
      test_stall();
      test_continuous_stop();
      test_cfg_err();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/nwr_pattern_gen.md
# nwr_pattern_gen

Parametrised NWRITE traffic generator for the SRIO logical layer. It is the successor to the fixed 8-size sweep generator. It produces back-to-back NWRITE packets on the user AXI-stream request interface with a run-time programmable length, address, stride, packet count and data pattern. Each packet is gated by the NWRITE engine's ready/busy/done status. It sits between the test/control registers and the NWRITE request path, and the core consumes user_tsize_o/user_addr_o per packet.

## Interface
- DATA_W, 64, stream width in bits; multiple of 8, BYTES=DATA_W/8 a power of two (8 or 16)
- ADDR_W, 34, target address width
- LEN_W, 9, byte-length field width; legal lengths 1..MAX_BYTES
- MAX_BYTES, 256, largest legal payload in bytes
- CNT_W, 16, packet-count width
- log_clk  in  1  clock
- log_rst  in  1  synchronous active-high reset
- start_in  in  1  one-cycle pulse; latches cfg_* and starts a run when idle
- stop_in  in  1  pulse; finish current packet, then end run
- cfg_len_in  in  LEN_W  payload bytes per packet
- cfg_base_addr_in  in  ADDR_W  address of first packet
- cfg_addr_step_in  in  ADDR_W  address increment per packet
- cfg_pkt_count_in  in  CNT_W  packets per run; 0 = continuous until stop_in
- cfg_mode_in  in  2  0 incrementing, 1 walking-one, 2 constant fill, 3 inverted incrementing
- cfg_fill_in  in  DATA_W  word for mode 2
- nwr_ready_in / nwr_busy_in / nwr_done_in  in  1 each  NWRITE engine status
- user_tready_in  in  1  stream ready
- user_addr_o  out  ADDR_W  packet address; stable for the whole packet
- user_tsize_o  out  20  latched length minus 1, zero-extended
- user_tdata_o  out  DATA_W  payload beat
- user_tvalid_o / user_tfirst_o / user_tlast_o  out  1 each  beat qualifiers
- user_tkeep_o  out  BYTES  byte enables; MSB lane = first byte
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle pulse at run end
- cfg_err_o  out  1  one-cycle pulse on rejected start
- pkt_cnt_o  out  CNT_W  packets completed in current/last run

## Operation
- States: IDLE, WAIT_RDY, SEND, WAIT_DONE.
- IDLE: start_in with 1 ≤ cfg_len_in ≤ MAX_BYTES latches all cfg_*. It clears pkt_cnt_o and the beat counter, loads addr = base, sets busy_o and goes to WAIT_RDY.
- Illegal length: start_in with cfg_len_in = 0 or > MAX_BYTES pulses cfg_err_o and stays in IDLE. start_in outside IDLE is ignored.
- WAIT_RDY: when nwr_ready_in=1 and nwr_busy_in=0, go to SEND.
- SEND: beats = ceil(len/BYTES).
  - A beat is accepted on tvalid & tready, and the beat index then increments.
  - Acceptance of the beat with index beats-1 (tlast) goes to WAIT_DONE.
- WAIT_DONE: nwr_done_in increments pkt_cnt_o. The run ends (IDLE, busy_o=0, done_o pulse) if pkt_cnt_o+1 == cfg_pkt_count (nonzero) or a stop is pending. Otherwise addr += step (modulo 2^ADDR_W) and go to WAIT_RDY.
- nwr_done_in in other states is ignored.
- stop_in in any non-IDLE state sets stop-pending. The current packet always completes; stop_in in WAIT_RDY ends the run immediately with done_o.
- Data, with g = global beat counter per run (not reset between packets), truncated to DATA_W:
  - mode 0: g
  - mode 1: one-hot bit (g mod DATA_W)
  - mode 2: cfg_fill_in
  - mode 3: ~g
- tkeep: all ones except on tlast. On tlast, r = len mod BYTES; r=0 gives all ones, else the top r bits are set (BYTES=8, r=3 → 8'hE0).
- tfirst is 1 on beat 0 of each packet only. For a single-beat packet tfirst and tlast are both 1.

## Timing
- Reset values: all outputs 0, user_tkeep_o 0, state IDLE, cfg registers 0.
- All outputs are registered, except tkeep/tfirst/tlast, which may decode registered state combinationally.
- start_in at cycle N gives busy_o=1 at N+1. The ready condition seen in WAIT_RDY at cycle M gives tvalid=1 with beat 0 at M+1.
- Stall: while tvalid=1 and tready=0, tdata/tkeep/tfirst/tlast/addr hold unchanged. tvalid never drops mid-packet, so beats are contiguous whenever tready=1.
- One beat per cycle at full throughput. tvalid=0 in the cycle after tlast is accepted.
- done_o and the final pkt_cnt_o update occur one cycle after the terminating nwr_done_in.
- log_rst mid-packet: the next cycle returns to reset values, with no tlast emitted.

## Test plan
- len=20, base=0x100, count=1, mode 0, tready=1: 3 beats, data 0,1,2, tkeep FF,FF,F0, tfirst only on beat 0, tsize=19, addr=0x100; done_o after nwr_done_in.
- len=256, step=0x100, count=3, mode 3: 32 beats/packet; addrs 0x0, 0x100, 0x200; beat 0 of packet 2 = ~64; pkt_cnt_o=3.
- len=8, count=2, tready toggling 1/0 every cycle: data/tkeep held while stalled; both packets single-beat with tfirst=tlast=1, tkeep FF.
- count=0, mode 1, stop_in during packet 4's second beat: packet 4 completes; done_o after its nwr_done_in; pkt_cnt_o=4; data on beat k is one-hot bit k.
- start_in with len=0 and with len=257: cfg_err_o pulses, busy_o stays 0; start_in while busy: ignored.
- log_rst asserted mid-packet then released: all outputs 0; a new start_in with len=1 gives one beat with tkeep 80.
